keypad_scan_ctrl: RTL

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scans a 4x4 keypad one column at a time, debounces a
// press on the first row seen, reports it once, then debounces the release.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   enable     scan enable; low returns to scanning with the column held
//   rows[3:0]  row sense lines, active-high, already synchronized
//   cols[3:0]  one-hot column drive
//   key_code   {row_index, col_index} of the last accepted key
//   key_valid  one-cycle pulse when a debounced press is accepted
//   key_held   high while the accepted key is held or its release debounces
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV        = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       cols_q, cols_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;

    logic [CNT_W-1:0] cnt_inc_c;
    logic [1:0]       row_low_c;
    logic [1:0]       col_enc_c;
    logic             row_hit_c;
    logic             div_last_c;
    logic             cnt_done_c;

    // Lowest asserted row wins when several rows are active at capture.
    always_comb begin
        row_low_c = 2'd3;
        if (rows[0])      row_low_c = 2'd0;
        else if (rows[1]) row_low_c = 2'd1;
        else if (rows[2]) row_low_c = 2'd2;
    end

    // One-hot column drive to column index.
    always_comb begin
        col_enc_c = 2'd0;
        case (cols_q)
            4'b0010: col_enc_c = 2'd1;
            4'b0100: col_enc_c = 2'd2;
            4'b1000: col_enc_c = 2'd3;
            default: col_enc_c = 2'd0;
        endcase
    end

    assign cnt_inc_c  = cnt_q + CNT_W'(1);
    assign cnt_done_c = (cnt_inc_c == CNT_W'(DEBOUNCE_CYCLES));
    assign row_hit_c  = rows[row_q];
    assign div_last_c = (div_q == DIV_W'(SCAN_DIV - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        row_d   = row_q;
        col_d   = col_q;
        cols_d  = cols_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;

        if (!enable) begin
            // Freeze the column, drop any press in progress, keep the last code.
            state_d = ST_SCAN;
            cnt_d   = '0;
            div_d   = '0;
            held_d  = 1'b0;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    held_d = 1'b0;
                    if (rows != 4'b0000) begin
                        row_d   = row_low_c;
                        col_d   = col_enc_c;
                        cnt_d   = CNT_W'(1);
                        div_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else if (div_last_c) begin
                        cols_d = {cols_q[2:0], cols_q[3]};
                        div_d  = '0;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    // Only the captured row matters; other rows are ignored.
                    if (row_hit_c) begin
                        if (cnt_done_c) begin
                            code_d  = {row_q, col_q};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_HELD;
                        end else begin
                            cnt_d = cnt_inc_c;
                        end
                    end else begin
                        cnt_d   = '0;
                        div_d   = '0;
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // Any activity restarts the release count.
                    if (rows == 4'b0000) begin
                        if (cnt_done_c) begin
                            cnt_d   = '0;
                            div_d   = '0;
                            cols_d  = {cols_q[2:0], cols_q[3]};
                            held_d  = 1'b0;
                            state_d = ST_SCAN;
                        end else begin
                            cnt_d = cnt_inc_c;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    div_d   = '0;
                    held_d  = 1'b0;
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SCAN;
            cnt_q   <= '0;
            div_q   <= '0;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            cols_q  <= 4'b0001;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cols_q  <= cols_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign cols      = cols_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule
